// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - multi-cycle fetch/next-PC sequencer for the core front end
module fetch_seq #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0]   TRAP_VEC = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [XLEN-1:0]   pc,
    output logic [31:0]       instruction,
    input  logic [XLEN-1:0]   i_imm,
    input  logic [XLEN-1:0]   sb_imm,
    input  logic [XLEN-1:0]   uj_imm,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              resolve_valid,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              misalign_err
);

    localparam logic [31:0]     NOP        = 32'h0000_0013;
    localparam logic [6:0]      OP_JAL     = 7'b1101111;
    localparam logic [6:0]      OP_BRANCH  = 7'b1100011;
    localparam logic [6:0]      OP_JALR    = 7'b1100111;
    localparam logic [XLEN-1:0] STEP       = XLEN'(4);
    localparam logic [XLEN-1:0] CLR_BIT0   = ~XLEN'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_RESOLVE, S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [6:0]      opcode;
    logic            is_jal, is_jalr, needs_resolve;
    logic            issue_fire, resolve_fire, pc_update;
    logic            check_align, trap;
    logic [XLEN-1:0] seq_pc, target;

    assign opcode        = instruction[6:0];
    assign is_jal        = (opcode == OP_JAL);
    assign is_jalr       = (opcode == OP_JALR);
    assign needs_resolve = (opcode == OP_BRANCH) || is_jalr;
    assign seq_pc        = pc + STEP;

    // A redirect in the same cycle wins and the completion is thrown away.
    assign issue_fire   = (state == S_ISSUE) && instr_ready && !redirect_valid && !needs_resolve;
    assign resolve_fire = (state == S_RESOLVE) && resolve_valid && !redirect_valid;
    assign pc_update    = issue_fire || resolve_fire;

    // Sequential pc+4 targets are exempt from the alignment check, even on wrap.
    always_comb begin
        target      = seq_pc;
        check_align = 1'b0;
        if (state == S_ISSUE) begin
            if (is_jal) begin
                target      = pc + uj_imm;
                check_align = 1'b1;
            end
        end else if (is_jalr) begin
            target      = (rs1_val + i_imm) & CLR_BIT0;
            check_align = 1'b1;
        end else if (branch_taken) begin
            target      = pc + sb_imm;
            check_align = 1'b1;
        end
    end

    assign trap = check_align && (target[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (en) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                // A grant accepted alongside a redirect still owes a response.
                if (imem_gnt) state_nxt = redirect_valid ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid) state_nxt = imem_rvalid ? S_FETCH : S_DRAIN;
                else if (imem_rvalid) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (redirect_valid) state_nxt = S_FETCH;
                else if (instr_ready) begin
                    if (needs_resolve) state_nxt = S_RESOLVE;
                    else               state_nxt = en ? S_FETCH : S_IDLE;
                end
            end
            S_RESOLVE: begin
                if (redirect_valid)     state_nxt = S_FETCH;
                else if (resolve_valid) state_nxt = en ? S_FETCH : S_IDLE;
            end
            S_DRAIN: begin
                if (imem_rvalid) state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state == S_FETCH);
        instr_valid = (state == S_ISSUE);
    end

    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            instruction  <= NOP;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= pc_update && trap;
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (pc_update) begin
                pc <= trap ? TRAP_VEC : target;
            end
            if ((state == S_WAIT) && imem_rvalid && !redirect_valid) begin
                instruction <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - directed self-checking bench for fetch_seq
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        rst, en;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata, pc, instruction;
    logic [31:0] i_imm, sb_imm, uj_imm, rs1_val, redirect_pc;
    logic        instr_valid, instr_ready, resolve_valid, branch_taken;
    logic        redirect_valid, misalign_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_seq dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc(pc), .instruction(instruction),
        .i_imm(i_imm), .sb_imm(sb_imm), .uj_imm(uj_imm),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .resolve_valid(resolve_valid), .branch_taken(branch_taken), .rs1_val(rs1_val),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign_err(misalign_err)
    );

    // Serve one fetch: wait for req, grant, then respond the following cycle.
    task automatic do_fetch(input logic [31:0] word, output logic [31:0] addr, output logic to);
        int n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        to = (n >= 50);
        addr = imem_addr;
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_rvalid = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc = target;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic accept;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        i_imm = 0; sb_imm = 0; uj_imm = 0; rs1_val = 0;
        instr_ready = 0; resolve_valid = 0; branch_taken = 0;
        redirect_valid = 0; redirect_pc = 0;
        repeat (2) @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=0", misalign_err); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
        total++; if (instruction !== 32'h13) begin bad++; $display("FAIL reset_instr got=%h exp=13", instruction); end
        rst = 1'b0;
    endtask

    task automatic test_first_fetch;
        logic [31:0] a; logic to;
        @(negedge clk);
        do_fetch(32'h0000_0013, a, to);
        total++; if (to) begin bad++; $display("FAIL first_timeout got=timeout exp=req"); end
        total++; if (a !== 32'h0) begin bad++; $display("FAIL first_addr got=%h exp=0", a); end
        total++; if (instr_valid !== 1'b1 || instruction !== 32'h13) begin
            bad++; $display("FAIL first_issue got=%b/%h exp=1/13", instr_valid, instruction); end
        accept();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            bad++; $display("FAIL first_next got=%b/%h exp=1/4", imem_req, imem_addr); end
    endtask

    task automatic test_jal;
        logic [31:0] a; logic to;
        do_redirect(32'h100);
        uj_imm = 32'h8;
        do_fetch(32'h0080_006F, a, to);
        total++; if (to || a !== 32'h100) begin bad++; $display("FAIL jal_addr got=%h exp=100", a); end
        accept();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin
            bad++; $display("FAIL jal_next got=%b/%h exp=1/108", imem_req, imem_addr); end
    endtask

    task automatic test_branch;
        logic [31:0] a; logic to;
        sb_imm = 32'hFFFF_FFF0;
        for (int t = 1; t >= 0; t--) begin
            do_redirect(32'h200);
            do_fetch(32'h0000_0063, a, to);
            accept();
            repeat (2) @(negedge clk);
            total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h200) begin
                bad++; $display("FAIL br_hold got=%b/%b/%h exp=0/0/200", instr_valid, imem_req, pc); end
            resolve_valid = 1'b1; branch_taken = (t == 1);
            @(negedge clk);
            resolve_valid = 1'b0; branch_taken = 1'b0;
            total++; if (imem_req !== 1'b1 || imem_addr !== (t == 1 ? 32'h1F0 : 32'h204)) begin
                bad++; $display("FAIL br_target taken=%0d got=%h exp=%h", t, imem_addr, (t == 1 ? 32'h1F0 : 32'h204)); end
        end
    endtask

    task automatic test_jalr;
        logic [31:0] a; logic to;
        do_redirect(32'h300);
        do_fetch(32'h0000_0067, a, to);
        accept();
        rs1_val = 32'h1001; i_imm = 32'h3;
        resolve_valid = 1'b1;
        @(negedge clk);
        resolve_valid = 1'b0;
        total++; if (imem_addr !== 32'h1004 || misalign_err !== 1'b0) begin
            bad++; $display("FAIL jalr_ok got=%h/%b exp=1004/0", imem_addr, misalign_err); end
        do_fetch(32'h0000_0067, a, to);
        accept();
        i_imm = 32'h2;
        resolve_valid = 1'b1;
        @(negedge clk);
        resolve_valid = 1'b0;
        total++; if (misalign_err !== 1'b1 || pc !== 32'h100 || imem_req !== 1'b1) begin
            bad++; $display("FAIL jalr_trap got=%b/%h/%b exp=1/100/1", misalign_err, pc, imem_req); end
        @(negedge clk);
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL jalr_pulse got=%b exp=0", misalign_err); end
    endtask

    task automatic test_redirect_wait;
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        do_redirect(32'h400);
        total++; if (imem_req !== 1'b0 || pc !== 32'h400) begin
            bad++; $display("FAIL drain_state got=%b/%h exp=0/400", imem_req, pc); end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        total++; if (instruction !== 32'h67) begin bad++; $display("FAIL drain_instr got=%h exp=67", instruction); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
            bad++; $display("FAIL drain_next got=%b/%h exp=1/400", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_issue;
        logic [31:0] a; logic to;
        do_fetch(32'h0080_006F, a, to);
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
        @(negedge clk);
        instr_ready = 1'b0; redirect_valid = 1'b0;
        total++; if (imem_addr !== 32'h500 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL redir_issue got=%h/%b exp=500/0", imem_addr, instr_valid); end
    endtask

    task automatic test_wrap;
        logic [31:0] a; logic to;
        do_redirect(32'hFFFF_FFFC);
        do_fetch(32'h0000_0013, a, to);
        total++; if (a !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h exp=fffffffc", a); end
        accept();
        total++; if (imem_addr !== 32'h0 || misalign_err !== 1'b0) begin
            bad++; $display("FAIL wrap_next got=%h/%b exp=0/0", imem_addr, misalign_err); end
    endtask

    task automatic test_en_low;
        logic [31:0] a; logic to;
        do_fetch(32'h0010_0093, a, to);
        en = 1'b0;
        accept();
        repeat (2) @(negedge clk);
        total++; if (imem_req !== 1'b0 || pc !== 32'h4) begin
            bad++; $display("FAIL idle_hold got=%b/%h exp=0/4", imem_req, pc); end
        do_redirect(32'h600);
        total++; if (imem_req !== 1'b0 || pc !== 32'h600) begin
            bad++; $display("FAIL idle_redir got=%b/%h exp=0/600", imem_req, pc); end
    endtask

    task automatic test_reset_mid;
        en = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        en = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (pc !== 32'h0 || imem_req !== 1'b0 || instruction !== 32'h13) begin
            bad++; $display("FAIL rst_async got=%h/%b/%h exp=0/0/13", pc, imem_req, instruction); end
        @(negedge clk);
        rst = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        @(negedge clk);
        total++; if (instruction !== 32'h13 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL rst_late got=%h/%b/%b exp=13/0/0", instruction, instr_valid, imem_req); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_jal();
        test_branch();
        test_jalr();
        test_redirect_wait();
        test_redirect_issue();
        test_wrap();
        test_en_low();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
